// File: rtl/nios2_cordic_sysinfo_pkg.sv
// Shared register-map constants for the sysinfo/uptime slave.
package nios2_cordic_sysinfo_pkg;

   localparam logic [3:0] ADDR_ID       = 4'd0;
   localparam logic [3:0] ADDR_TS       = 4'd1;
   localparam logic [3:0] ADDR_CTRL     = 4'd2;
   localparam logic [3:0] ADDR_CNT_LO   = 4'd3;
   localparam logic [3:0] ADDR_CNT_HI   = 4'd4;
   localparam logic [3:0] ADDR_SCRATCH0 = 4'd8;

   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_CLR  = 1;
   localparam int unsigned CTRL_WRAP = 2;

endpackage

// File: rtl/nios2_cordic_sysinfo_counter.sv
// Free-running cycle counter with enable, clear, wrap pulse and a
// high-word snapshot captured when the low word is read.
module nios2_cordic_sysinfo_counter #(
   parameter int unsigned CNT_W = 48
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             snap,
   output logic [CNT_W-1:0] count,
   output logic             wrap,
   output logic [31:0]      snapshot
);

   // Clear suppresses the wrap event as well as the increment.
   assign wrap = en && !clr && (count == '1);

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   generate
      if (CNT_W > 32) begin : g_hi
         always_ff @(posedge clock) begin
            if (reset) begin
               snapshot <= '0;
            end else if (snap) begin
               snapshot <= 32'(count[CNT_W-1:32]);
            end
         end
      end else begin : g_no_hi
         assign snapshot = '0;
      end
   endgenerate

endmodule

// File: rtl/nios2_cordic_sysinfo.sv
// System ID / uptime Avalon-MM slave: ID words, cycle counter with coherent
// 64-bit readout, CTRL/WRAP status and scratch registers; read latency 1.
module nios2_cordic_sysinfo
   import nios2_cordic_sysinfo_pkg::*;
#(
   parameter logic [31:0] SYSID_ID        = 32'h0000_0000,
   parameter logic [31:0] SYSID_TIMESTAMP = 32'h0000_0000,
   parameter int unsigned CNT_W           = 48,
   parameter int unsigned NUM_SCRATCH     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   logic             en_q;
   logic             wrap_q;
   logic [31:0]      scratch [NUM_SCRATCH];
   logic             wr_ctrl;
   logic             clr;
   logic             snap;
   logic             wrap_pulse;
   logic [CNT_W-1:0] count;
   logic [31:0]      snapshot;
   logic [31:0]      rd_mux;

   assign wr_ctrl = write && (address == ADDR_CTRL);
   assign clr     = wr_ctrl && writedata[CTRL_CLR];
   assign snap    = read && (address == ADDR_CNT_LO);

   nios2_cordic_sysinfo_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clock    (clock),
      .reset    (reset),
      .en       (en_q),
      .clr      (clr),
      .snap     (snap),
      .count    (count),
      .wrap     (wrap_pulse),
      .snapshot (snapshot)
   );

   // A wrap event outranks a simultaneous W1C of the sticky flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         en_q   <= 1'b1;
         wrap_q <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en_q <= writedata[CTRL_EN];
         end
         if (wrap_pulse) begin
            wrap_q <= 1'b1;
         end else if (wr_ctrl && writedata[CTRL_WRAP]) begin
            wrap_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            scratch[i] <= '0;
         end
      end else if (write) begin
         for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            if (address == 4'(ADDR_SCRATCH0 + i)) begin
               scratch[i] <= writedata;
            end
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_ID:     rd_mux = SYSID_ID;
         ADDR_TS:     rd_mux = SYSID_TIMESTAMP;
         ADDR_CTRL: begin
            rd_mux[CTRL_EN]   = en_q;
            rd_mux[CTRL_WRAP] = wrap_q;
         end
         ADDR_CNT_LO: rd_mux = 32'(count);
         ADDR_CNT_HI: rd_mux = snapshot;
         default: begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
               if (address == 4'(ADDR_SCRATCH0 + i)) begin
                  rd_mux = scratch[i];
               end
            end
         end
      endcase
   end

   // Mux sees pre-edge state, so a colliding write is not reflected in the read.
   always_ff @(posedge clock) begin
      if (reset) begin
         readdatavalid <= 1'b0;
         readdata      <= '0;
      end else begin
         readdatavalid <= read;
         readdata      <= read ? rd_mux : '0;
      end
   end

endmodule

// File: tb/tb_nios2_cordic_sysinfo.sv
// Directed bench: a 40-bit instance with ID words and an 8-bit instance
// share one bus so wrap behaviour can be reached in a few hundred cycles.
module tb_nios2_cordic_sysinfo;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] rd_a, rd_b;
   logic        rdv_a, rdv_b;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always #5 clock = ~clock;

   nios2_cordic_sysinfo #(
      .SYSID_ID        (32'h56E1_D382),
      .SYSID_TIMESTAMP (32'h5E7F_0002),
      .CNT_W           (40),
      .NUM_SCRATCH     (2)
   ) dut_a (
      .clock         (clock),
      .reset         (reset),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .readdata      (rd_a),
      .readdatavalid (rdv_a)
   );

   nios2_cordic_sysinfo #(
      .CNT_W       (8),
      .NUM_SCRATCH (2)
   ) dut_b (
      .clock         (clock),
      .reset         (reset),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .readdata      (rd_b),
      .readdatavalid (rdv_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [3:0] a);
      @(negedge clock);
      address = a;
      read    = 1'b1;
      @(posedge clock);
      #1;
      read = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clock);
      address   = a;
      writedata = d;
      write     = 1'b1;
      @(posedge clock);
      #1;
      write = 1'b0;
   endtask

   task automatic rw(input logic [3:0] a, input logic [31:0] d);
      @(negedge clock);
      address   = a;
      writedata = d;
      write     = 1'b1;
      read      = 1'b1;
      @(posedge clock);
      #1;
      write = 1'b0;
      read  = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset state
      idle(3);
      chk("rst_rdv", 32'(rdv_a), 32'd0);
      chk("rst_rd", rd_a, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // ID / timestamp / unmapped word
      rd(4'd0);
      chk("id_rdv", 32'(rdv_a), 32'd1);
      chk("id", rd_a, 32'h56E1_D382);
      idle(1);
      chk("gap_rdv", 32'(rdv_a), 32'd0);
      chk("gap_rd", rd_a, 32'd0);
      rd(4'd1);
      chk("ts", rd_a, 32'h5E7F_0002);
      rd(4'd5);
      chk("w5_rdv", 32'(rdv_a), 32'd1);
      chk("w5", rd_a, 32'd0);

      // Scratch, RO write, unmapped scratch slot, read/write collision
      wr(4'd8, 32'hDEAD_BEEF);
      wr(4'd9, 32'h1234_5678);
      rd(4'd8);
      chk("scr0", rd_a, 32'hDEAD_BEEF);
      rd(4'd9);
      chk("scr1", rd_a, 32'h1234_5678);
      wr(4'd0, 32'hFFFF_FFFF);
      rd(4'd0);
      chk("id_ro", rd_a, 32'h56E1_D382);
      wr(4'd10, 32'hFFFF_FFFF);
      rd(4'd10);
      chk("w10", rd_a, 32'd0);
      rw(4'd8, 32'hA5A5_A5A5);
      chk("rw_old", rd_a, 32'hDEAD_BEEF);
      rd(4'd8);
      chk("rw_new", rd_a, 32'hA5A5_A5A5);
      wr(4'd2, 32'hFFFF_FFF9);
      rd(4'd2);
      chk("ctrl_hi_ign", rd_a, 32'd1);

      // Coherent 40-bit readout across a carry
      wr(4'd2, 32'd0);
      @(negedge clock);
      force dut_a.u_counter.count = 40'hFF_FFFF_FFFE;
      @(posedge clock);
      @(negedge clock);
      release dut_a.u_counter.count;
      rd(4'd3);
      chk("lo40", rd_a, 32'hFFFF_FFFE);
      wr(4'd2, 32'd1);
      idle(5);
      rd(4'd4);
      chk("hi40_snap", rd_a, 32'h0000_00FF);
      rd(4'd3);
      chk("lo40_wrapped", rd_a, 32'd4);
      rd(4'd4);
      chk("hi40_new", rd_a, 32'd0);
      rd(4'd2);
      chk("a_wrap", rd_a, 32'd5);
      wr(4'd2, 32'd5);
      rd(4'd2);
      chk("a_w1c", rd_a, 32'd1);

      // 8-bit wrap, sticky flag, W1C collision with wrap
      wr(4'd2, 32'd7);
      idle(255);
      rd(4'd3);
      chk("b_max", rd_b, 32'h0000_00FF);
      rd(4'd3);
      chk("b_zero", rd_b, 32'd0);
      rd(4'd2);
      chk("b_wrap", rd_b, 32'd5);
      idle(253);
      wr(4'd2, 32'd5);
      rd(4'd2);
      chk("b_w1c_on_wrap", rd_b, 32'd5);
      wr(4'd2, 32'd5);
      rd(4'd2);
      chk("b_w1c", rd_b, 32'd1);
      rd(4'd4);
      chk("b_hi", rd_b, 32'd0);

      // CLR while counting, then hold with EN=0
      wr(4'd2, 32'd3);
      rd(4'd3);
      chk("clr_a0", rd_a, 32'd0);
      chk("clr_b0", rd_b, 32'd0);
      rd(4'd3);
      chk("clr_a1", rd_a, 32'd1);
      wr(4'd2, 32'd0);
      rd(4'd3);
      chk("hold_a", rd_a, 32'd3);
      idle(10);
      rd(4'd3);
      chk("hold_a10", rd_a, 32'd3);
      chk("hold_b10", rd_b, 32'd3);
      wr(4'd2, 32'd2);
      rd(4'd3);
      chk("clr_off", rd_a, 32'd0);
      idle(3);
      rd(4'd3);
      chk("clr_off_held", rd_a, 32'd0);
      rd(4'd2);
      chk("ctrl_off", rd_a, 32'd0);

      // Reset mid-count with a read on the reset cycle
      wr(4'd2, 32'd1);
      idle(4);
      @(negedge clock);
      reset   = 1'b1;
      read    = 1'b1;
      address = 4'd3;
      @(posedge clock);
      #1;
      read = 1'b0;
      chk("rst_rd_rdv_a", 32'(rdv_a), 32'd0);
      chk("rst_rd_rdv_b", 32'(rdv_b), 32'd0);
      chk("rst_rd_data", rd_a, 32'd0);
      reset = 1'b0;
      rd(4'd3);
      chk("post_cnt_a", rd_a, 32'd0);
      chk("post_cnt_b", rd_b, 32'd0);
      rd(4'd2);
      chk("post_ctrl", rd_a, 32'd1);
      rd(4'd8);
      chk("post_scr0", rd_a, 32'd0);
      rd(4'd9);
      chk("post_scr1", rd_a, 32'd0);
      rd(4'd4);
      chk("post_snap", rd_a, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/nios2_cordic_sysinfo.md
# nios2_cordic_sysinfo

Parametrised system-identification and uptime peripheral on the Nios II / CORDIC Qsys fabric. Successor to the fixed two-word ID slave. It exposes ID and timestamp words, a free-running cycle counter with coherent 64-bit readout, control and wrap status, and software scratch registers. Reads go through a registered Avalon-MM slave with fixed one-cycle read latency, so software can time code and probe the bus without extra IP.

## Interface
Parameters:
- SYSID_ID, 32'h0000_0000: value returned at word 0.
- SYSID_TIMESTAMP, 32'h0000_0000: value returned at word 1 (generation time, seconds).
- CNT_W, 48: cycle counter width, legal range 1..64.
- NUM_SCRATCH, 2: number of 32-bit scratch registers, legal range 1..4.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  4  word address.
- read  in  1  read strobe, one cycle per access.
- write  in  1  write strobe, one cycle per access.
- writedata  in  32  write data.
- readdata  out  32  read data, valid only with readdatavalid.
- readdatavalid  out  1  one-cycle pulse, one cycle after the accepted read.

## Operation
- Register map, by word:
  - 0: ID (RO).
  - 1: TIMESTAMP (RO).
  - 2: CTRL.
    - bit0 EN: RW, reset 1.
    - bit1 CLR: write-1 pulse, reads 0.
    - bit2 WRAP: sticky, W1C.
  - 3: CNT_LO (RO).
  - 4: CNT_HI (RO snapshot).
  - 8..8+NUM_SCRATCH-1: SCRATCH (RW).
  - All other words read 0; writes to them are ignored.
- Counter:
  - Increments by 1 each cycle while EN=1.
  - Wraps from 2^CNT_W-1 to 0 and sets WRAP on that cycle.
- Coherent readout:
  - A read of CNT_LO returns counter bits [31:0].
  - The same read captures bits [CNT_W-1:32] into the HI snapshot, zero-extended.
  - A read of CNT_HI returns the snapshot, not the live counter.
  - If CNT_W<=32, CNT_LO is the zero-extended counter and CNT_HI always reads 0.
- Writes to RO words (0, 1, 3, 4) have no effect.
- Writes to CTRL bits [31:3] are ignored. Scratch registers accept all 32 bits.
- Simultaneous events:
  - CLR and an increment in the same cycle: CLR wins, counter becomes 0.
  - CLR and a wrap in the same cycle: counter becomes 0 and WRAP is not set.
  - WRAP W1C in the same cycle as a wrap event: set wins, WRAP stays 1.
  - CLR does not alter WRAP. EN written 0 together with CLR=1: counter is 0 and held.
  - read and write in the same cycle (illegal on the fabric): the write takes effect, and the read returns the pre-write value.
- Reset, synchronous:
  - counter=0, EN=1, WRAP=0, snapshot=0, scratch=0.
  - readdatavalid=0, readdata=0.
  - A read accepted on the cycle reset is asserted produces no readdatavalid.

## Timing
- No waitrequest: every access is accepted in the cycle it is presented.
- Read latency is exactly 1.
  - readdata and readdatavalid are registered outputs.
  - readdata returns to 0 on any cycle where readdatavalid=0.
- Back-to-back reads are supported at one per cycle.
- A CNT_LO read at cycle N returns the counter value held in the register at cycle N, before that cycle's increment. The snapshot captures the same value.
- Write effects are visible to a read issued on the next cycle.
- CLR written at cycle N: counter reads 0 at N+1, then 1 at N+2 if EN=1.

## Structure
- Shared package nios2_cordic_sysinfo_pkg holds:
  - word-address localparams (ADDR_ID=0, ADDR_TS=1, ADDR_CTRL=2, ADDR_CNT_LO=3, ADDR_CNT_HI=4, ADDR_SCRATCH0=8);
  - CTRL bit indices.
- One sub-module, nios2_cordic_sysinfo_counter. It contains:
  - the CNT_W counter with EN and CLR;
  - the wrap pulse output;
  - snapshot capture on a strobe.
- The top level contains address decode, CTRL/WRAP, the scratch registers and the registered read mux.

## Test plan
- Reset, then read words 0, 1 and 5 with SYSID_ID=32'h56E1_D382 and TIMESTAMP=32'h5E7F_0002 → readdatavalid one cycle later with 32'h56E1_D382, 32'h5E7F_0002 and 0. readdata=0 between reads.
- Write 32'hDEAD_BEEF to word 8 and 32'h1234_5678 to word 9, then read back → the same values. Write to word 0 → ID unchanged.
- With CNT_W=40, force the counter to 40'hFF_FFFF_FFFE, read CNT_LO then CNT_HI several cycles later → 32'hFFFF_FFFE, then 32'h0000_00FF, unaffected by the intervening carry.
- With CNT_W=8, run to the wrap → counter 0, WRAP=1. Write CTRL=3'b100 on a wrap cycle → WRAP stays 1. Write 3'b100 on a non-wrap cycle → WRAP=0.
- Write CTRL=2'b11 while counting → CNT_LO reads 0 on the next cycle, then increments. Write EN=0 → two reads 10 cycles apart return equal values.
- Assert reset mid-count with a read issued on the same cycle → no readdatavalid. Afterwards counter=0, EN=1 and scratch=0.
